// File: rtl/layer_three_dense_pkg.sv
// Shared definitions for the binary conv/dense classifier pipeline:
// top-level FSM state encodings, layer geometry and the feature-map index convention.
package layer_three_dense_pkg;

  localparam logic [2:0] s_LAYER_2 = 3'b011;
  localparam logic [2:0] s_LAYER_3 = 3'b100;

  localparam int N_CLASSES = 10;
  localparam int N_FEAT    = 196;
  localparam int CHUNK     = 49;
  localparam int N_PLANES  = N_FEAT / CHUNK;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } l3_fsm_t;

  // Flat bit position of a conv-2 output: filter plane wn, 7x7 spatial grid.
  function automatic int feat_idx(input int wn, input int row, input int col);
    return wn * CHUNK + row * 7 + col;
  endfunction

endpackage

// File: rtl/layer_three_dense_popcount49.sv
// Combinational population count of a 49-bit vector (0..49).
// Zero latency, no flow control.
module popcount49 (
  input  logic [48:0] vec_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 49; i++) begin
      cnt_o = cnt_o + 6'(vec_i[i]);
    end
  end

endmodule

// File: rtl/layer_three_dense.sv
// XNOR-popcount dense classifier: one 49-bit plane per cycle, one compare per class, argmax out.
// 51 cycles from first s_LAYER_3 edge to done; stalls in place whenever state leaves s_LAYER_3.
module layer_three_dense
  import layer_three_dense_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  state,
  input  logic [N_FEAT-1:0]           features,
  input  logic [N_CLASSES*N_FEAT-1:0] weights,
  output logic [3:0]                  digit,
  output logic [7:0]                  best_score,
  output logic                        done
);

  l3_fsm_t     fsm_q;
  logic [3:0]  cls_q;
  logic [1:0]  chunk_q;
  logic [7:0]  acc_q;
  logic [7:0]  acc_d;
  logic [3:0]  digit_q;
  logic [7:0]  best_q;
  logic        done_q;

  logic [7:0]       fbase;
  logic [10:0]      wbase;
  logic [CHUNK-1:0] match;
  logic [5:0]       pc;
  logic             go;

  assign go    = (state == s_LAYER_3);
  assign fbase = 8'(chunk_q) * 8'(CHUNK);
  assign wbase = 11'(cls_q) * 11'(N_FEAT) + 11'(chunk_q) * 11'(CHUNK);
  assign match = ~(features[fbase +: CHUNK] ^ weights[wbase +: CHUNK]);
  assign acc_d = acc_q + 8'(pc);

  popcount49 u_popcount (
    .vec_i (match),
    .cnt_o (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cls_q   <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      digit_q <= '0;
      best_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (go) begin
            fsm_q   <= ACCUM;
            acc_q   <= '0;
            cls_q   <= '0;
            chunk_q <= '0;
          end
        end
        ACCUM: begin
          if (go) begin
            acc_q <= acc_d;
            if (chunk_q == 2'd3) begin
              fsm_q   <= COMPARE;
              chunk_q <= '0;
            end else begin
              chunk_q <= chunk_q + 2'd1;
            end
          end
        end
        COMPARE: begin
          if (go) begin
            // Strict compare: on a tie the earlier (lower) class stays the winner.
            if (cls_q == 4'd0 || acc_q > best_q) begin
              digit_q <= cls_q;
              best_q  <= acc_q;
            end
            acc_q <= '0;
            if (cls_q == 4'(N_CLASSES - 1)) begin
              fsm_q  <= DONE;
              done_q <= 1'b1;
            end else begin
              cls_q <= cls_q + 4'd1;
              fsm_q <= ACCUM;
            end
          end
        end
        DONE: begin
          fsm_q <= DONE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign digit      = digit_q;
  assign best_score = best_q;
  assign done       = done_q;

endmodule
